// File: rtl/async_fifo_wr_packer.sv
// Write-side packer for an async FIFO: gathers G_IN_WIDTH-bit beats into
// G_WIDTH-bit words (first beat in the LSBs) and issues FIFO writes.
module async_fifo_wr_packer #(
  parameter int G_WIDTH    = 8,
  parameter int G_IN_WIDTH = 2
) (
  input  logic                  i_clk_w,
  input  logic                  i_arstN_w,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [G_IN_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_fifo_full,
  output logic                  o_wren,
  output logic [G_WIDTH-1:0]    o_data_w,
  output logic                  o_partial,
  output logic [15:0]           o_word_cnt
);

  localparam int R  = G_WIDTH / G_IN_WIDTH;
  localparam int CW = (R > 2) ? $clog2(R) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(R - 1);

  generate
    if ((G_WIDTH % G_IN_WIDTH) != 0 || R < 2) begin : g_bad_ratio
      $error("async_fifo_wr_packer: G_WIDTH/G_IN_WIDTH must be an integer >= 2");
    end
  endgenerate

  typedef enum logic {
    EMPTY = 1'b0,
    PEND  = 1'b1
  } state_t;

  state_t              r_state;
  logic [G_WIDTH-1:0]  r_acc;
  logic [CW-1:0]       r_cnt;
  logic [G_WIDTH-1:0]  r_out_data;
  logic [15:0]         r_word_cnt;

  logic                w_out_valid;
  logic                w_wren;
  logic                w_ready;
  logic                w_accept;
  logic                w_complete;
  logic [G_WIDTH-1:0]  w_merged;

  assign w_out_valid = (r_state == PEND);
  assign w_wren      = w_out_valid && !i_fifo_full;
  assign w_ready     = !w_out_valid || !i_fifo_full;
  assign w_accept    = i_valid && w_ready;
  assign w_complete  = w_accept && ((r_cnt == C_LAST) || i_last);

  // Slots above the current one are always zero in the accumulator, so the
  // merged word already has unfilled slots cleared when a frame ends early.
  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_slot
      assign w_merged[gi*G_IN_WIDTH +: G_IN_WIDTH] =
        (r_cnt == CW'(gi)) ? i_data : r_acc[gi*G_IN_WIDTH +: G_IN_WIDTH];
    end
  endgenerate

  always_ff @(posedge i_clk_w or negedge i_arstN_w) begin
    if (!i_arstN_w) begin
      r_state    <= EMPTY;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          r_out_data <= w_merged;
          r_acc      <= '0;
          r_cnt      <= '0;
        end else begin
          r_acc      <= w_merged;
          r_cnt      <= r_cnt + 1'b1;
        end
      end

      // A word completing while the previous one drains keeps the slot full.
      case (r_state)
        EMPTY:   if (w_complete) r_state <= PEND;
        PEND:    if (w_wren && !w_complete) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase

      if (w_wren) r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign o_ready    = w_ready;
  assign o_wren     = w_wren;
  assign o_data_w   = r_out_data;
  assign o_partial  = (r_cnt != '0);
  assign o_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_async_fifo_wr_packer.sv
// Directed bench for async_fifo_wr_packer with G_WIDTH=8, G_IN_WIDTH=2.
module tb_async_fifo_wr_packer;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        valid;
  logic        ready;
  logic [1:0]  din;
  logic        last;
  logic        full;
  logic        wren;
  logic [7:0]  dout;
  logic        partial;
  logic [15:0] wcnt;

  int total = 0;
  int bad   = 0;

  async_fifo_wr_packer #(.G_WIDTH(8), .G_IN_WIDTH(2)) dut (
    .i_clk_w     (clk),
    .i_arstN_w   (arst_n),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_data      (din),
    .i_last      (last),
    .i_fifo_full (full),
    .o_wren      (wren),
    .o_data_w    (dout),
    .o_partial   (partial),
    .o_word_cnt  (wcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wren"},    {31'd0, wren},    32'd0);
    chk({tag, "_data"},    {24'd0, dout},    32'd0);
    chk({tag, "_partial"}, {31'd0, partial}, 32'd0);
    chk({tag, "_ready"},   {31'd0, ready},   32'd1);
    chk({tag, "_wcnt"},    {16'd0, wcnt},    32'd0);
  endtask

  logic [1:0] beat_tab [64];
  logic [7:0] exp_word;

  initial begin
    arst_n = 1'b0;
    valid  = 1'b0;
    din    = 2'd0;
    last   = 1'b0;
    full   = 1'b0;
    #2;
    chk_reset_outputs("reset");
    cyc();
    cyc();
    arst_n = 1'b1;
    cyc();

    // Four contiguous beats 1,2,3,0 -> 0x39
    valid = 1'b1;
    din = 2'd1; cyc();
    chk("t1_partial_b1", {31'd0, partial}, 32'd1);
    din = 2'd2; cyc();
    din = 2'd3; cyc();
    chk("t1_nowren_b3", {31'd0, wren}, 32'd0);
    din = 2'd0; cyc();
    valid = 1'b0;
    chk("t1_wren",    {31'd0, wren},    32'd1);
    chk("t1_data",    {24'd0, dout},    32'h39);
    chk("t1_partial", {31'd0, partial}, 32'd0);
    cyc();
    chk("t1_wren_off", {31'd0, wren}, 32'd0);
    chk("t1_wcnt",     {16'd0, wcnt}, 32'd1);

    // Short frame 3,1 with last -> 0x07
    valid = 1'b1;
    din = 2'd3; cyc();
    chk("t2_partial_b1", {31'd0, partial}, 32'd1);
    din = 2'd1; last = 1'b1; cyc();
    valid = 1'b0; last = 1'b0;
    chk("t2_wren",    {31'd0, wren},    32'd1);
    chk("t2_data",    {24'd0, dout},    32'h07);
    chk("t2_partial", {31'd0, partial}, 32'd0);
    cyc();
    chk("t2_wcnt", {16'd0, wcnt}, 32'd2);

    // Backpressure: word 0xAA pending while FIFO full for 5 cycles
    full = 1'b1;
    valid = 1'b1;
    din = 2'd2;
    for (int i = 0; i < 4; i++) cyc();
    din = 2'd3;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_wren",  {31'd0, wren},  32'd0);
      chk("t3_stall_ready", {31'd0, ready}, 32'd0);
      chk("t3_stall_data",  {24'd0, dout},  32'hAA);
      cyc();
    end
    valid = 1'b0;
    full = 1'b0;
    #1;
    chk("t3_release_wren",  {31'd0, wren},  32'd1);
    chk("t3_release_ready", {31'd0, ready}, 32'd1);
    chk("t3_release_data",  {24'd0, dout},  32'hAA);
    cyc();
    chk("t3_after_wren", {31'd0, wren}, 32'd0);
    chk("t3_wcnt",       {16'd0, wcnt}, 32'd3);

    // 64 contiguous beats -> 16 words, one write every 4th cycle
    for (int i = 0; i < 64; i++) beat_tab[i] = 2'((i * 3 + (i >> 2)) & 3);
    valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      din = beat_tab[i];
      chk("t4_ready", {31'd0, ready}, 32'd1);
      cyc();
      if ((i % 4) == 3) begin
        exp_word = {beat_tab[i], beat_tab[i-1], beat_tab[i-2], beat_tab[i-3]};
        chk("t4_wren", {31'd0, wren}, 32'd1);
        chk("t4_data", {24'd0, dout}, {24'd0, exp_word});
      end else begin
        chk("t4_nowren", {31'd0, wren}, 32'd0);
      end
    end
    valid = 1'b0;
    cyc();
    chk("t4_wcnt", {16'd0, wcnt}, 32'd19);

    // Reset in the middle of a word discards it
    valid = 1'b1;
    din = 2'd1; cyc();
    din = 2'd1; cyc();
    valid = 1'b0;
    arst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_reset");
    cyc();
    arst_n = 1'b1;
    valid = 1'b1;
    din = 2'd0; cyc();
    din = 2'd0; cyc();
    din = 2'd0; cyc();
    din = 2'd1; cyc();
    valid = 1'b0;
    chk("t5_wren", {31'd0, wren}, 32'd1);
    chk("t5_data", {24'd0, dout}, 32'h40);
    cyc();
    chk("t5_wcnt", {16'd0, wcnt}, 32'd1);

    // Word counter wrap: single-beat frames give one write per cycle
    valid = 1'b1;
    last = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      din = 2'(i);
      cyc();
    end
    valid = 1'b0;
    last = 1'b0;
    chk("t6_wcnt_max",  {16'd0, wcnt},    32'hFFFF);
    chk("t6_last_wren", {31'd0, wren},    32'd1);
    chk("t6_last_data", {24'd0, dout},    32'h02);
    cyc();
    chk("t6_wcnt_wrap", {16'd0, wcnt}, 32'd0);
    chk("t6_idle_wren", {31'd0, wren}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
